// File: rtl/fsb_pkg.sv
// Shared definitions for the multi-channel 68000 bus-cycle sequencer:
// parameter defaults, the FSM state enum and a select-index width helper.
package fsb_pkg;

    localparam int FSB_NCS_DEF   = 4;
    localparam int FSB_WSW_DEF   = 3;
    localparam int FSB_TOW_DEF   = 8;
    localparam int FSB_TOLIM_DEF = 200;

    typedef enum logic [2:0] {
        FSB_IDLE = 3'd0,
        FSB_WAIT = 3'd1,
        FSB_ACK  = 3'd2,
        FSB_BERR = 3'd3,
        FSB_TERM = 3'd4
    } fsb_state_e;

    // Width of a channel index; a single channel still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fsb_multi_if.sv
// 68000-side bus bundle for fsb_multi. The master modport is the CPU /
// address-decode side, the slave modport is the sequencer itself.
interface fsb_multi_if
    import fsb_pkg::*;
#(
    parameter int NCS = FSB_NCS_DEF,
    parameter int WSW = FSB_WSW_DEF
);
    logic               nAS;
    logic               nDTACK;
    logic               nVPA;
    logic               nBERR;
    logic               ASrf;
    logic               BACT;
    logic               BACTr;
    logic [NCS-1:0]     CS;
    logic [NCS-1:0]     RDY;
    logic [NCS*WSW-1:0] WS;
    logic [NCS-1:0]     PW;
    logic               IOPWCS;
    logic               IOPWReady;
    logic               IONPReady;
    logic               QoSEN;
    logic [NCS-1:0]     QOSM;
    logic               IACKCS;
    logic               TOEN;
    logic               BUSY;

    modport master (
        output nAS, CS, RDY, WS, PW, IOPWCS, IOPWReady, IONPReady,
               QoSEN, QOSM, IACKCS, TOEN,
        input  nDTACK, nVPA, nBERR, ASrf, BACT, BACTr, BUSY
    );

    modport slave (
        input  nAS, CS, RDY, WS, PW, IOPWCS, IOPWReady, IONPReady,
               QoSEN, QOSM, IACKCS, TOEN,
        output nDTACK, nVPA, nBERR, ASrf, BACT, BACTr, BUSY
    );

endinterface

// File: rtl/fsb_prienc.sv
// Lowest-index-first priority encoder for the chip-select vector.
module fsb_prienc
    import fsb_pkg::*;
#(
    parameter int N = FSB_NCS_DEF,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    output logic          vld,
    output logic [IW-1:0] idx
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        vld = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                vld = 1'b1;
                idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/fsb_multi.sv
// 68000 bus-cycle sequencer: latches the selected channel when AS falls,
// waits for that channel (or an I/O source) to be ready, then drives
// DTACK, VPA or BERR until AS is released.
//
// state | meaning
// IDLE  | no bus cycle, waiting for nAS low
// WAIT  | cycle open, counting wait states, evaluating acknowledge/timeout
// ACK   | nDTACK or nVPA held low until nAS rises
// BERR  | nBERR held low until nAS rises
// TERM  | one-cycle recovery before IDLE
module fsb_multi
    import fsb_pkg::*;
#(
    parameter int NCS   = FSB_NCS_DEF,
    parameter int WSW   = FSB_WSW_DEF,
    parameter int TOW   = FSB_TOW_DEF,
    parameter int TOLIM = FSB_TOLIM_DEF
) (
    input  logic       FCLK,
    input  logic       RST,
    fsb_multi_if.slave bus
);

    localparam int IW = idx_width(NCS);

    localparam logic [2:0] S_IDLE = 3'(FSB_IDLE);
    localparam logic [2:0] S_WAIT = 3'(FSB_WAIT);
    localparam logic [2:0] S_ACK  = 3'(FSB_ACK);
    localparam logic [2:0] S_BERR = 3'(FSB_BERR);
    localparam logic [2:0] S_TERM = 3'(FSB_TERM);

    logic [2:0]     state;
    logic [TOW-1:0] cnt;
    logic [TOW-1:0] cnt_now;
    logic           sel_vld;
    logic [IW-1:0]  sel;
    logic           enc_vld;
    logic [IW-1:0]  enc_idx;
    logic           dtack_q;
    logic           vpa_q;
    logic           berr_q;
    logic           asrf_q;
    logic           bactr_q;
    logic           bact;
    logic [WSW-1:0] ws_arr [NCS];
    logic [TOW-1:0] ws_sel;
    logic           grant;
    logic           ack_dt;
    logic           ack_vpa;
    logic           tmo;

    fsb_prienc #(.N(NCS)) u_prienc (
        .req (bus.CS),
        .vld (enc_vld),
        .idx (enc_idx)
    );

    for (genvar i = 0; i < NCS; i++) begin : g_ws
        assign ws_arr[i] = bus.WS[i*WSW +: WSW];
    end

    // cnt holds completed WAIT cycles; cnt_now also counts the cycle being
    // evaluated, so WS=n grants on the n-th edge spent in WAIT.
    always_comb begin
        cnt_now = (cnt == {TOW{1'b1}}) ? cnt : cnt + TOW'(1);
        ws_sel  = TOW'(ws_arr[sel]);
        grant   = sel_vld && bus.RDY[sel] && (cnt_now >= ws_sel)
                  && !(bus.QOSM[sel] && bus.QoSEN)
                  && !(bus.PW[sel] && bus.IOPWCS && !bus.IOPWReady);
        ack_dt  = !bus.IACKCS && (grant || bus.IONPReady);
        ack_vpa = bus.IACKCS && bus.IOPWReady;
        tmo     = bus.TOEN && (cnt_now >= TOW'(TOLIM));
    end

    // AS sampled on the falling edge, half a cycle behind the strobe.
    always_ff @(negedge FCLK or posedge RST) begin
        if (RST) asrf_q <= 1'b0;
        else     asrf_q <= !bus.nAS;
    end

    // Registered copy of bus-active.
    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) bactr_q <= 1'b0;
        else     bactr_q <= bact;
    end

    // Cycle sequencer; acknowledges take priority over the timeout.
    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sel_vld <= 1'b0;
            sel     <= '0;
            dtack_q <= 1'b0;
            vpa_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (!bus.nAS) begin
                        state   <= S_WAIT;
                        cnt     <= '0;
                        sel_vld <= enc_vld;
                        sel     <= enc_idx;
                    end
                end
                S_WAIT: begin
                    if (bus.nAS) begin
                        state <= S_TERM;
                    end else if (ack_vpa) begin
                        state <= S_ACK;
                        vpa_q <= 1'b1;
                    end else if (ack_dt) begin
                        state   <= S_ACK;
                        dtack_q <= 1'b1;
                    end else if (tmo) begin
                        state  <= S_BERR;
                        berr_q <= 1'b1;
                    end else begin
                        cnt <= cnt_now;
                    end
                end
                S_ACK, S_BERR: begin
                    if (bus.nAS) begin
                        state   <= S_TERM;
                        dtack_q <= 1'b0;
                        vpa_q   <= 1'b0;
                        berr_q  <= 1'b0;
                    end
                end
                S_TERM:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes are gated by AS so they release the moment the CPU lets go.
    assign bact       = !bus.nAS || asrf_q;
    assign bus.nDTACK = !(dtack_q && !bus.nAS);
    assign bus.nVPA   = !(vpa_q && !bus.nAS);
    assign bus.nBERR  = !(berr_q && !bus.nAS);
    assign bus.ASrf   = asrf_q;
    assign bus.BACT   = bact;
    assign bus.BACTr  = bactr_q;
    assign bus.BUSY   = (state != S_IDLE);

endmodule

// File: tb/tb_fsb_multi.sv
// Bench for fsb_multi: directed scenarios plus random bus cycles, each
// checked against a per-cycle prediction of which strobe fires and when.
module tb_fsb_multi;

    localparam int LIMIT = 215;
    localparam int NEVER = 1000;

    typedef struct packed {
        logic [3:0]  cs, rdy0, rdy1, pw, qosm;
        logic [11:0] ws;
        logic        iopwcs, iopwready, qosen0, iack, toen;
        int          k_sw, ionp_at;
    } txn_t;

    logic FCLK;
    logic RST;
    int   n_chk;
    int   n_err;

    fsb_multi_if bus ();

    fsb_multi dut (
        .FCLK (FCLK),
        .RST  (RST),
        .bus  (bus)
    );

    initial FCLK = 1'b0;
    always #5 FCLK = ~FCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int strobe_kind();
        if (!bus.nDTACK) return 1;
        if (!bus.nVPA)   return 2;
        if (!bus.nBERR)  return 3;
        return 0;
    endfunction

    function automatic int strobe_lows();
        return int'(!bus.nDTACK) + int'(!bus.nVPA) + int'(!bus.nBERR);
    endfunction

    // Edge n counts rising edges from the one that first samples nAS low.
    // A cycle spent n-1 edges in WAIT by edge n; return first acknowledging
    // edge and strobe kind (1 DTACK, 2 VPA, 3 BERR), or 0/0 for none.
    function automatic void predict(input txn_t t, output int e, output int k);
        int         sel;
        logic [3:0] rdy;
        logic       qe, ionp, grant;
        int         waited;
        sel = -1;
        for (int i = 0; i < 4; i++) if (t.cs[i] && sel < 0) sel = i;
        e = 0;
        k = 0;
        for (int n = 2; n <= LIMIT; n++) begin
            rdy    = (n >= t.k_sw) ? t.rdy1 : t.rdy0;
            qe     = (n < t.k_sw) && t.qosen0;
            ionp   = (n >= t.ionp_at);
            waited = n - 1;
            grant  = 1'b0;
            if (sel >= 0)
                grant = rdy[sel] && (waited >= int'(t.ws[sel*3 +: 3]))
                        && !(t.qosm[sel] && qe)
                        && !(t.pw[sel] && t.iopwcs && !t.iopwready);
            if (t.iack ? t.iopwready : (grant || ionp)) begin
                e = n;
                k = t.iack ? 2 : 1;
                return;
            end
            if (t.toen && waited >= 200) begin
                e = n;
                k = 3;
                return;
            end
        end
    endfunction

    task automatic apply_cfg(input txn_t t);
        bus.CS        = t.cs;
        bus.WS        = t.ws;
        bus.PW        = t.pw;
        bus.QOSM      = t.qosm;
        bus.IOPWCS    = t.iopwcs;
        bus.IOPWReady = t.iopwready;
        bus.IACKCS    = t.iack;
        bus.TOEN      = t.toen;
    endtask

    task automatic drive_dyn(input txn_t t, input int n);
        bus.RDY       = (n >= t.k_sw) ? t.rdy1 : t.rdy0;
        bus.QoSEN     = (n < t.k_sw) && t.qosen0;
        bus.IONPReady = (n >= t.ionp_at);
    endtask

    function automatic txn_t base();
        txn_t t;
        t = '0;
        t.k_sw    = 2;
        t.ionp_at = NEVER;
        return t;
    endfunction

    task automatic run_txn(input txn_t t, input string tag, output int obs_e);
        int exp_e, exp_k, obs_k, multi;
        predict(t, exp_e, exp_k);
        @(negedge FCLK); #1;
        bus.nAS = 1'b0;
        apply_cfg(t);
        drive_dyn(t, 1);
        obs_e = 0;
        obs_k = 0;
        multi = 0;
        for (int n = 1; n <= LIMIT && obs_e == 0; n++) begin
            @(posedge FCLK); #1;
            if (n == 1) begin
                chk({tag, "_bact"},  int'(bus.BACT), 1);
                chk({tag, "_bactr"}, int'(bus.BACTr), 1);
                chk({tag, "_asrf0"}, int'(bus.ASrf), 0);
                chk({tag, "_busy"},  int'(bus.BUSY), 1);
            end
            if (strobe_lows() > 1) multi = 1;
            if (strobe_lows() > 0) begin
                obs_e = n;
                obs_k = strobe_kind();
            end
            @(negedge FCLK); #1;
            drive_dyn(t, n + 1);
            if (n == 1) bus.CS = 4'($urandom);
        end
        chk({tag, "_edge"}, obs_e, exp_e);
        chk({tag, "_kind"}, obs_k, exp_k);
        if (obs_e != 0) begin
            @(posedge FCLK); #1;
            if (strobe_lows() > 1) multi = 1;
            chk({tag, "_hold"}, strobe_kind(), exp_k);
        end
        chk({tag, "_excl"}, multi, 0);
        @(posedge FCLK); #3;
        bus.nAS = 1'b1;
        #1;
        chk({tag, "_rel"}, int'({bus.nDTACK, bus.nVPA, bus.nBERR}), 7);
        chk({tag, "_bact_hold"}, int'(bus.BACT), 1);
        @(posedge FCLK); #1;
        chk({tag, "_term"}, int'(bus.BUSY), 1);
        chk({tag, "_bact_off"}, int'(bus.BACT), 0);
        chk({tag, "_bactr_off"}, int'(bus.BACTr), 0);
        @(posedge FCLK); #1;
        chk({tag, "_idle"}, int'(bus.BUSY), 0);
    endtask

    task automatic rst_mid(input txn_t t, input int k, input string tag);
        @(negedge FCLK); #1;
        bus.nAS = 1'b0;
        apply_cfg(t);
        drive_dyn(t, 1);
        repeat (k) @(posedge FCLK);
        #1;
        if (k >= 3) chk({tag, "_pre"}, strobe_kind(), 1);
        #2;
        RST = 1'b1;
        #1;
        chk({tag, "_busy"},  int'(bus.BUSY), 0);
        chk({tag, "_strb"},  int'({bus.nDTACK, bus.nVPA, bus.nBERR}), 7);
        chk({tag, "_bactr"}, int'(bus.BACTr), 0);
        chk({tag, "_asrf"},  int'(bus.ASrf), 0);
        #1;
        bus.nAS = 1'b1;
        @(posedge FCLK);
        @(negedge FCLK); #1;
        RST = 1'b0;
        @(posedge FCLK); #1;
        chk({tag, "_stay_idle"}, int'(bus.BUSY), 0);
    endtask

    initial begin
        txn_t t, t28;
        int   e;
        n_chk = 0;
        n_err = 0;
        RST = 1'b1;
        bus.nAS = 1'b1;
        apply_cfg(base());
        drive_dyn(base(), 1);
        #12;
        chk("rst_strb",  int'({bus.nDTACK, bus.nVPA, bus.nBERR}), 7);
        chk("rst_asrf",  int'(bus.ASrf), 0);
        chk("rst_bactr", int'(bus.BACTr), 0);
        chk("rst_busy",  int'(bus.BUSY), 0);
        @(negedge FCLK); #1;
        RST = 1'b0;

        t28 = base();
        t28.cs = 4'b0001; t28.rdy0 = 4'hF; t28.rdy1 = 4'hF; t28.ws = 12'h002;
        run_txn(t28, "r028", e);
        chk("r028_lat", e, 3);

        t = base();
        t.cs = 4'b0001; t.rdy0 = 4'hF; t.rdy1 = 4'hF;
        t.qosm = 4'b0001; t.qosen0 = 1'b1; t.k_sw = 6;
        run_txn(t, "r029", e);
        chk("r029_lat", e, 6);

        t = base();
        t.cs = 4'b0110; t.rdy0 = 4'b0100; t.rdy1 = 4'b0110; t.k_sw = 8;
        run_txn(t, "r030", e);
        chk("r030_lat", e, 8);

        t = base();
        t.cs = 4'b0001; t.rdy0 = 4'hF; t.rdy1 = 4'hF;
        t.iack = 1'b1; t.iopwready = 1'b1; t.ionp_at = 2;
        run_txn(t, "r031", e);
        chk("r031_lat", e, 2);

        t = base();
        t.toen = 1'b1;
        run_txn(t, "r032_to", e);
        chk("r032_to_lat", e, 201);
        t.ionp_at = 201;
        run_txn(t, "r032_race", e);
        chk("r032_race_lat", e, 201);

        t = base();
        t.cs = 4'b0001; t.rdy0 = 4'hF; t.rdy1 = 4'hF;
        t.pw = 4'b0001; t.iopwcs = 1'b1;
        run_txn(t, "pw_block", e);
        chk("pw_block_none", e, 0);

        rst_mid(t28, 1, "r033_wait");
        run_txn(t28, "r033_after", e);
        chk("r033_after_lat", e, 3);
        rst_mid(t28, 4, "r033_ack");

        for (int i = 0; i < 40; i++) begin
            t = base();
            t.cs        = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            t.rdy0      = 4'($urandom);
            t.rdy1      = t.rdy0 | 4'($urandom);
            t.ws        = 12'($urandom);
            t.pw        = 4'($urandom);
            t.qosm      = 4'($urandom);
            t.iopwcs    = 1'($urandom_range(0, 1));
            t.iopwready = 1'($urandom_range(0, 1));
            t.qosen0    = 1'($urandom_range(0, 1));
            t.iack      = ($urandom_range(0, 3) == 0);
            t.toen      = 1'($urandom_range(0, 1));
            t.k_sw      = int'($urandom_range(2, 20));
            t.ionp_at   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(2, 30)) : NEVER;
            run_txn(t, $sformatf("rnd%0d", i), e);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fsb_multi.md
FSB_MULTI -- requirements
Module: fsb_multi

Interface
REQ-001 Parameter NCS, default 4: number of chip-select channels, 1..8.
REQ-002 Parameter WSW, default 3: width of each per-channel minimum wait-state field.
REQ-003 Parameter TOW, default 8: timeout counter width; TOLIM, default 200: timeout limit in FCLK cycles, less than 2^TOW.
REQ-004 Ports SHALL be as follows; one clock (FCLK), reset asynchronous active-high (RST).
- FCLK  in  1  bus clock.
- RST  in  1  asynchronous active-high reset.
- nAS  in  1  68000 address strobe, active low.
- nDTACK  out  1  data transfer acknowledge, active low.
- nVPA  out  1  valid peripheral address (autovector acknowledge), active low.
- nBERR  out  1  bus error, active low.
- ASrf  out  1  AS sampled on the FCLK falling edge.
- BACT  out  1  bus active, combinational.
- BACTr  out  1  BACT registered on the FCLK rising edge.
- CS  in  NCS  channel selects.
- RDY  in  NCS  channel ready.
- WS  in  NCS*WSW  minimum wait cycles per channel; channel i uses bits [i*WSW +: WSW].
- PW  in  NCS  channel subject to posted-write gating.
- IOPWCS  in  1  posted-write buffer busy/select.
- IOPWReady  in  1  posted-write buffer ready.
- IONPReady  in  1  non-posted I/O ready; this is an unconditional acknowledge.
- QoSEN  in  1  QoS stall; blocks acknowledges from RAM/ROM-class channels.
- QOSM  in  NCS  per-channel mask; 1 means the channel obeys QoSEN.
- IACKCS  in  1  interrupt acknowledge cycle.
- TOEN  in  1  timeout/bus-error enable.
- BUSY  out  1  FSM not IDLE.

Function
REQ-005 ASrf SHALL equal !nAS registered on the FCLK falling edge.
REQ-006 BACT SHALL be !nAS || ASrf.
REQ-007 BACTr SHALL be BACT registered on the FCLK rising edge.
REQ-008 The FSM SHALL have the states IDLE, WAIT, ACK, BERR and TERM, and SHALL advance on the FCLK rising edge.
REQ-009 IDLE -> WAIT when nAS is low; on that edge, clear the cycle counter and latch SEL, the lowest-index asserted CS bit, with SEL = none if no CS bit is set.
REQ-010 The cycle counter SHALL increment each cycle in WAIT and saturate at 2^TOW-1.
REQ-011 Channel grant in WAIT: all of the following must hold.
- SEL valid and RDY[SEL].
- Counter >= WS[SEL].
- !(QOSM[SEL] && QoSEN).
- !(PW[SEL] && IOPWCS && !IOPWReady).
REQ-012 WAIT -> ACK, with nDTACK driven low, when !IACKCS and (channel grant or IONPReady).
REQ-013 WAIT -> ACK, with nVPA driven low, when IACKCS and IOPWReady; nDTACK SHALL NOT assert in IACK cycles.
REQ-014 WAIT -> BERR, with nBERR driven low, when TOEN, the counter has reached TOLIM, and no acknowledge condition holds on that edge.
REQ-015 If an acknowledge condition and the timeout occur on the same edge, the acknowledge SHALL win.
REQ-016 With TOEN low, WAIT SHALL be held indefinitely.
REQ-017 In ACK and BERR the active strobe SHALL remain asserted until nAS goes high.
REQ-018 nAS high SHALL asynchronously deassert nDTACK, nVPA and nBERR.
REQ-019 The FSM SHALL move to TERM on the next edge after nAS goes high, then to IDLE on the following edge.
REQ-020 nAS going high while in WAIT SHALL abort the cycle: go to TERM with no strobe asserted.
REQ-021 At most one of nDTACK, nVPA and nBERR SHALL be low at any time.
REQ-022 Each acknowledge strobe SHALL first assert on the FCLK rising edge at which its condition is sampled (1-cycle latency).
REQ-023 Changes to CS after the IDLE -> WAIT edge SHALL be ignored for the rest of the cycle.

Reset
REQ-024 RST high SHALL asynchronously set nDTACK=1, nVPA=1, nBERR=1, ASrf=0, BACTr=0, state=IDLE, counter=0, SEL=none.
REQ-025 RST asserted mid-cycle SHALL abort that cycle; after RST releases, a new cycle starts only once nAS is sampled low in IDLE.

Structure
REQ-026 Shared package fsb_pkg SHALL hold the FSM state enum and the TOLIM/WSW defaults.
REQ-027 The lowest-index select encoder SHALL be the sub-module fsb_prienc (NCS in; valid flag and index out); everything else stays in fsb_multi.

Verification
REQ-028 CS=0001, RDY[0]=1, WS[0]=2, QOSM=0: nDTACK low on the 3rd rising edge after nAS falls; nDTACK high asynchronously at nAS rise.
REQ-029 CS=0001, QOSM[0]=1, QoSEN=1 for 5 cycles, then 0: nDTACK asserts on the first edge after QoSEN drops.
REQ-030 CS=0110, RDY=0100, then RDY=0110: SEL=1, so nDTACK asserts only when RDY[1] rises.
REQ-031 IACKCS=1, IOPWReady=1: nVPA low, nDTACK stays high throughout.
REQ-032 TOEN=1, CS=0: nBERR low after 200 cycles; with IONPReady rising at cycle 200, nDTACK asserts instead and nBERR stays high.
REQ-033 RST pulsed in WAIT: all strobes high and state IDLE immediately; the next nAS low starts a normal cycle.
